// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan controller: glyph table,
// blank pattern, slot phase type and the slot-length helper.
package fnd_pkg;

  // Segment order is {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [7:0] SEG_BLANK = 8'hff;

  localparam logic [7:0] GLYPH [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
  };

  // Within a digit slot, the guard phase comes first and the drive phase follows it.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_e;

  // Clock cycles per digit slot.
  function automatic int fnd_div_f(input int clk_hz, input int scan_hz, input int num_digits);
    return clk_hz / (scan_hz * num_digits);
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Nibble to active-low segment pattern, with decimal point and blanking.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Look up the glyph. Blanking switches off a-g but leaves the dp alone.
  always_comb begin
    o_seg = {~i_dp, (i_blank ? 7'h7f : GLYPH[i_nib][6:0])};
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller. It provides frame-latched page
// selection, leading-zero suppression, per-digit blink and guard intervals.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_PAGES  = 2,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD      = 2,
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PW-1:0]                 page_sel,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] digits,
  input  logic [NUM_PAGES*NUM_DIGITS-1:0]   dp,
  input  logic                          lz_en,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [7:0]                    fnd_data,
  output logic [NUM_DIGITS-1:0]         fnd_com
);

  localparam int DIV  = fnd_div_f(CLK_HZ, SCAN_HZ, NUM_DIGITS);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  generate
    if (DIV < GUARD + 1) begin : g_div_check
      $error("fnd_scan_ctrl: slot length DIV must be at least GUARD+1");
    end
  endgenerate

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [PW-1:0]           r_page_q;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_ph;
  logic [NUM_DIGITS-1:0]   r_fnd_com;
  logic [7:0]              r_fnd_data;

  logic [PW-1:0]           w_page_next;
  logic [NUM_DIGITS*4-1:0] w_page_digits;
  logic [NUM_DIGITS-1:0]   w_page_dp;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_lz_blank;
  logic                    w_blink_off;
  logic [NUM_DIGITS-1:0]   w_com_drive;
  logic [7:0]              w_seg;
  slot_phase_e             w_phase;

  // Map an out-of-range page request to page 0 before it is latched.
  always_comb begin
    w_page_next = page_sel;
    if (int'(page_sel) >= NUM_PAGES) w_page_next = '0;
  end

  // Slot counter and digit index. The page is latched only on the frame wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_page_q <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      if (r_idx == IDX_LAST) begin
        r_idx    <= '0;
        r_page_q <= w_page_next;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Free-running blink timer. The phase starts in the visible state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= ~r_blink_ph;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Pick the latched page's nibbles and decimal points out of the packed inputs.
  always_comb begin
    w_page_digits = digits[NUM_DIGITS*4-1:0];
    w_page_dp     = dp[NUM_DIGITS-1:0];
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (int'(r_page_q) == p) begin
        w_page_digits = digits[p*NUM_DIGITS*4 +: NUM_DIGITS*4];
        w_page_dp     = dp[p*NUM_DIGITS +: NUM_DIGITS];
      end
    end
  end

  // For the current digit, select its nibble and dp, decide whether it is a
  // suppressed leading zero, apply blink, and form the common pattern.
  always_comb begin
    w_nib       = 4'h0;
    w_dp        = 1'b0;
    w_lz_blank  = lz_en && (r_idx != '0);
    w_blink_off = 1'b0;
    w_com_drive = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (int'(r_idx) == d) begin
        w_nib          = w_page_digits[d*4 +: 4];
        w_dp           = w_page_dp[d];
        w_blink_off    = blink_mask[d] && !r_blink_ph;
        w_com_drive[d] = 1'b0;
      end
      if ((d >= int'(r_idx)) && (w_page_digits[d*4 +: 4] != 4'h0)) w_lz_blank = 1'b0;
    end
  end

  // Classify the current cycle as guard or drive within the slot.
  always_comb begin
    w_phase = (r_cnt < GUARD_C) ? PH_GUARD : PH_DRIVE;
  end

  fnd_seg_decode u_dec (
    .i_nib   (w_nib),
    .i_dp    (w_dp),
    .i_blank (w_lz_blank),
    .o_seg   (w_seg)
  );

  // Register commons and segments together so they change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fnd_com  <= '1;
      r_fnd_data <= SEG_BLANK;
    end else if (w_phase == PH_GUARD) begin
      r_fnd_com  <= '1;
      r_fnd_data <= SEG_BLANK;
    end else begin
      r_fnd_com  <= w_com_drive;
      r_fnd_data <= w_blink_off ? SEG_BLANK : w_seg;
    end
  end

  assign fnd_com  = r_fnd_com;
  assign fnd_data = r_fnd_data;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl. A cycle-arithmetic reference model is checked
// every cycle, and fixed scenarios pin known output values.
module tb_fnd_scan_ctrl;

  localparam int ND     = 4;
  localparam int NP     = 3;
  localparam int CLKHZ  = 1000;
  localparam int SCANHZ = 50;
  localparam int BLHZ   = 10;
  localparam int GD     = 1;
  localparam int DIVB   = CLKHZ / (SCANHZ * ND);
  localparam int HALFB  = CLKHZ / (2 * BLHZ);
  localparam int FRAME  = ND * DIVB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      page_sel = '0;
  logic [NP*ND*4-1:0] digitsIn = '0;
  logic [NP*ND-1:0]   dpIn = '0;
  logic            lzEn = 1'b0;
  logic [ND-1:0]   blinkMask = '0;
  logic [7:0]      fndData;
  logic [ND-1:0]   fndCom;

  int total = 0;
  int bad   = 0;
  bit cmpEn = 1'b0;

  int         mCycle = 0;
  int         mPage  = 0;
  logic [3:0] expCom  = 4'hf;
  logic [7:0] expData = 8'hff;

  logic [7:0] tbGlyph [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
  };

  fnd_scan_ctrl #(
    .NUM_DIGITS (ND),
    .NUM_PAGES  (NP),
    .CLK_HZ     (CLKHZ),
    .SCAN_HZ    (SCANHZ),
    .BLINK_HZ   (BLHZ),
    .GUARD      (GD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .page_sel   (page_sel),
    .digits     (digitsIn),
    .dp         (dpIn),
    .lz_en      (lzEn),
    .blink_mask (blinkMask),
    .fnd_data   (fndData),
    .fnd_com    (fndCom)
  );

  always #5 clk = ~clk;

  // Reference model. It uses the cycle number since the reset release and
  // the inputs sampled on this edge. It produces the output pattern this
  // edge must register.
  initial begin : model
    int cnt;
    int idx;
    int nib;
    logic [15:0] pageVal;
    logic [7:0]  glyph;
    logic        lzb;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mCycle  = 0;
        mPage   = 0;
        expCom  = 4'hf;
        expData = 8'hff;
      end else begin
        cnt = mCycle % DIVB;
        idx = (mCycle / DIVB) % ND;
        if (cnt < GD) begin
          expCom  = 4'hf;
          expData = 8'hff;
        end else begin
          pageVal = 16'(digitsIn >> (mPage * 16));
          nib     = int'((pageVal >> (idx * 4)) & 16'h000f);
          glyph   = tbGlyph[nib];
          lzb     = lzEn && (idx > 0) && ((pageVal >> (idx * 4)) == 16'h0);
          expCom  = 4'hf & ~(4'b0001 << idx);
          expData = {~dpIn[mPage*ND + idx], (lzb ? 7'h7f : glyph[6:0])};
          if (((mCycle / HALFB) % 2 == 1) && blinkMask[idx]) expData = 8'hff;
        end
        if (mCycle % FRAME == FRAME - 1) mPage = (int'(page_sel) >= NP) ? 0 : int'(page_sel);
        mCycle++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] c, input logic [7:0] d);
    total++;
    if (fndCom !== c || fndData !== d) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got com=%b data=%h, want com=%b data=%h",
               name, $time, fndCom, fndData, c, d);
    end
  endtask

  // Check the DUT against the model every cycle, away from the clock edge.
  initial begin : compare
    wait (cmpEn);
    forever begin
      @(negedge clk);
      #1;
      if (!rst) checkOutput("reset_live", 4'hf, 8'hff);
      else      checkOutput("model", expCom, expData);
    end
  end

  // Wait until the output of edge k after the reset release is visible.
  task automatic waitRel(input int k);
    int n = 0;
    while (mCycle < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (mCycle < k) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_edge_%0d: reached %0d, required %0d", k, mCycle, k);
    end
    #2;
  endtask

  task automatic checkAt(input int k, input string name, input logic [3:0] c, input logic [7:0] d);
    waitRel(k);
    checkOutput(name, c, d);
  endtask

  task automatic startRun();
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("reset_hold", 4'hf, 8'hff);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] p0, input logic [3:0] dp0,
                               input logic lz, input logic [3:0] bm, input logic [1:0] ps);
    digitsIn  = {16'habcd, 16'h5678, p0};
    dpIn      = {4'b0000, 4'b0000, dp0};
    lzEn      = lz;
    blinkMask = bm;
    page_sel  = ps;
  endtask

  logic [3:0] seqCom [20] = '{
    4'hf, 4'he, 4'he, 4'he, 4'he, 4'hf, 4'hd, 4'hd, 4'hd, 4'hd,
    4'hf, 4'hb, 4'hb, 4'hb, 4'hb, 4'hf, 4'h7, 4'h7, 4'h7, 4'h7
  };
  logic [7:0] seqData [20] = '{
    8'hff, 8'h99, 8'h99, 8'h99, 8'h99, 8'hff, 8'hb0, 8'hb0, 8'hb0, 8'hb0,
    8'hff, 8'h24, 8'h24, 8'h24, 8'h24, 8'hff, 8'hf9, 8'hf9, 8'hf9, 8'hf9
  };

  initial begin : stimulus
    int r;
    #1 rst = 1'b0;
    #2 cmpEn = 1'b1;

    // First frame: slot sequence, glyphs with dp on digit2, and a page request mid-frame.
    applyStimulus(16'h1234, 4'b0100, 1'b0, 4'b0000, 2'd0);
    startRun();
    for (int k = 1; k <= 20; k++) begin
      checkAt(k, "first_frame", seqCom[k-1], seqData[k-1]);
      if (k == 12) page_sel = 2'd1;
    end
    checkAt(23, "page1_digit0", 4'b1110, 8'h80);
    checkAt(28, "page1_digit1", 4'b1101, 8'hf8);

    // Leading-zero suppression, then live data change to all zeros.
    applyStimulus(16'h0007, 4'b0000, 1'b1, 4'b0000, 2'd0);
    startRun();
    checkAt(3,  "lz_digit0", 4'b1110, 8'hf8);
    checkAt(8,  "lz_digit1", 4'b1101, 8'hff);
    checkAt(13, "lz_digit2", 4'b1011, 8'hff);
    checkAt(18, "lz_digit3", 4'b0111, 8'hff);
    digitsIn[15:0] = 16'h0000;
    checkAt(23, "lz0_digit0", 4'b1110, 8'hc0);
    checkAt(28, "lz0_digit1", 4'b1101, 8'hff);
    checkAt(38, "lz0_digit3", 4'b0111, 8'hff);

    // Blink on digit 0 only.
    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0001, 2'd0);
    startRun();
    checkAt(3,   "blink_on",     4'b1110, 8'h99);
    checkAt(8,   "blink_steady", 4'b1101, 8'hb0);
    checkAt(63,  "blink_off",    4'b1110, 8'hff);
    checkAt(68,  "blink_other",  4'b1101, 8'hb0);
    checkAt(103, "blink_on2",    4'b1110, 8'h99);

    // Reset pulse while digit 2 is being driven.
    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0000, 2'd1);
    startRun();
    checkAt(12, "pre_pulse", 4'b1011, 8'ha4);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid", 4'hf, 8'hff);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkAt(1,  "pulse_guard",  4'hf, 8'hff);
    checkAt(2,  "pulse_digit0", 4'b1110, 8'h99);
    checkAt(22, "pulse_page1",  4'b1110, 8'h80);

    // Randomised traffic checked by the model.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        for (int i = 0; i < NP*ND; i++)
          digitsIn[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end else if (r < 12) begin
        dpIn = 12'($urandom);
      end else if (r < 16) begin
        lzEn = ~lzEn;
      end else if (r < 20) begin
        blinkMask = 4'($urandom);
      end else if (r < 30) begin
        page_sel = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised, time-multiplexed 7-segment (FND) scan controller for the stopwatch/clock designs. It drives `NUM_DIGITS` common-anode digits from `NUM_PAGES` selectable pages of BCD/hex data. Each digit carries its own decimal point, and the block adds leading-zero suppression, per-digit blinking, frame-aligned page switching and an anti-ghosting guard interval. It sits between the time counters (after digit splitting) and the board's FND pins.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned (≥2)
- `NUM_PAGES`, 2, number of selectable data pages (≥1)
- `CLK_HZ`, 100_000_000, system clock frequency
- `SCAN_HZ`, 1_000, full-frame refresh rate
- `BLINK_HZ`, 2, blink rate (on+off period = 1/BLINK_HZ)
- `GUARD`, 2, cycles per slot with all commons off (≥0)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset; one clock domain
- `page_sel` in $clog2(NUM_PAGES) (min 1): requested page
- `digits` in NUM_PAGES*NUM_DIGITS*4: packed nibbles; page p digit d at bits [(p*NUM_DIGITS+d)*4 +: 4]; digit 0 is rightmost
- `dp` in NUM_PAGES*NUM_DIGITS: decimal point per page/digit, 1 = lit
- `lz_en` in 1: leading-zero suppression enable
- `blink_mask` in NUM_DIGITS: 1 = digit blinks
- `fnd_data` out 8: segments {dp,g,f,e,d,c,b,a}, active-low
- `fnd_com` out NUM_DIGITS: digit commons, active-low, one-hot-low or all-high

## Operation
- `DIV = CLK_HZ/(SCAN_HZ*NUM_DIGITS)` (integer division). A slot counter `cnt` counts 0..DIV-1 and a digit index `idx` counts 0..NUM_DIGITS-1, wrapping.
- Elaboration error if `DIV < GUARD+1`.
- Slot phases:
  - GUARD: `cnt < GUARD`. `fnd_com` all 1, `fnd_data` 8'hff.
  - DRIVE: `cnt ≥ GUARD`. `fnd_com[idx]`=0, all other commons 1.
- At `cnt==DIV-1`, `idx` advances. When `idx` wraps NUM_DIGITS-1→0, `page_sel` is sampled into `page_q`. Page changes therefore take effect only at frame boundaries, and no frame mixes pages.
- `page_sel ≥ NUM_PAGES` is treated as page 0.
- Glyphs (active-low) for nibble 0–F: c0,f9,a4,b0,99,92,82,f8,80,90,88,83,c6,a1,86,8e. `fnd_data[7]` = ~dp of the current digit.
- Leading-zero suppression (`lz_en`=1): a digit d>0 is blank (segments a–g off) if its nibble and all higher nibbles of `page_q` are 0. Digit 0 is never blanked. The dp bit is unaffected.
- Blink: a free-running counter toggles `blink_ph` every CLK_HZ/(2*BLINK_HZ) cycles; reset value is 1 (on). When `blink_ph`=0, digits with `blink_mask` set output 8'hff while their common is still driven.
- Data, dp, `lz_en` and `blink_mask` are used live; only the page is frame-latched.

## Timing
- Reset (rst=0), asynchronous:
  - `cnt`=0, `idx`=0, `page_q`=0, `blink_ph`=1
  - outputs `fnd_com`=all 1, `fnd_data`=8'hff
- Outputs are registered and reflect the `cnt`/`idx`/input state of the previous cycle (1-cycle latency).
- `fnd_com` and `fnd_data` update on the same edge; they are never glitched between slots.
- Per slot: GUARD cycles blank, then DIV-GUARD cycles driven. Frame length = NUM_DIGITS*DIV cycles.
- A `page_sel` change in the same cycle as the wrap is captured in that frame.
- Reset mid-scan: outputs go blank immediately; after release, scanning restarts at digit 0, page 0.

## Structure
- Package `fnd_pkg`: the 16-entry glyph constant array, `SEG_BLANK`=8'hff, and the `fnd_div_f` function that computes DIV.
- Sub-module `fnd_seg_decode` (combinational): nibble, dp, blank → 8-bit segment pattern.
- Top level holds the slot/digit counters, page latch, blink timer, leading-zero logic and output registers.

## Test plan
Test parameters: CLK_HZ=1000, SCAN_HZ=50, NUM_DIGITS=4, GUARD=1, BLINK_HZ=10. This gives DIV=5 and a blink half-period of 50 cycles.
- Reset: hold rst=0 → `fnd_com`=4'b1111, `fnd_data`=8'hff. After release, `fnd_com` sequence is 1111 ×1, 1110 ×4, 1111 ×1, 1101 ×4, 1111 ×1, 1011 ×4, 1111 ×1, 0111 ×4, then repeats.
- Page 0 = 1,2,3,4 (digit3..0), dp only on digit2 → `fnd_data` per digit 0..3 = 99, b0, 24, f9.
- `lz_en`=1, page 0 = 0,0,0,7 → digits 3..1 = ff, digit0 = f8. Page 0 = 0000 → digit0 = c0, others ff.
- `page_sel` 0→1 while `idx`=2 → digits 2,3 still show page 0; page 1 appears from digit 0 of the next frame.
- `blink_mask`=4'b0001 → digit0 shows its glyph for 50 cycles, then ff for 50 cycles. Other digits are steady.
- rst pulsed low while `idx`=2 → same-cycle blank outputs; after release, digit 0 is the first driven slot and page is 0.
